// File: rtl/mppt_pkg.sv
// Shared types and constants for the MPPT power-stage blocks.
// Holds the gate FSM state encoding and the default duty clamp limits.
package mppt_pkg;
    localparam int DUTY_W       = 8;
    localparam int DUTY_MIN_DEF = 8;
    localparam int DUTY_MAX_DEF = 240;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_HI    = 3'd1,
        ST_DT_HL = 3'd2,
        ST_LO    = 3'd3,
        ST_DT_LH = 3'd4
    } gate_state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] d,
        input logic [DUTY_W-1:0] lo,
        input logic [DUTY_W-1:0] hi
    );
        if (d < lo)
            return lo;
        else if (d > hi)
            return hi;
        else
            return d;
    endfunction
endpackage

// File: rtl/pwm_deadtime_fsm.sv
// Complementary gate-drive FSM: turns the raw PWM level into hi/lo drives
// separated by a dead-time interval, swallowing pulses shorter than the gap.
module pwm_deadtime_fsm
    import mppt_pkg::*;
#(
    parameter int DT_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               raw,
    input  logic [DT_BITS-1:0] dt_sh,
    output logic               pwm_hi,
    output logic               pwm_lo
);
    gate_state_t        state;
    logic [DT_BITS-1:0] dt_cnt;

    // Outputs are assigned alongside each state change so they stay registered
    // and always equal (state==HI) / (state==LO).
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            state  <= ST_OFF;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    state  <= raw ? ST_DT_LH : ST_DT_HL;
                    dt_cnt <= dt_sh;
                end
                ST_LO: begin
                    if (raw) begin
                        state  <= ST_DT_LH;
                        dt_cnt <= dt_sh;
                        pwm_lo <= 1'b0;
                    end
                end
                ST_HI: begin
                    if (!raw) begin
                        state  <= ST_DT_HL;
                        dt_cnt <= dt_sh;
                        pwm_hi <= 1'b0;
                    end
                end
                ST_DT_LH: begin
                    // raw already dropped: the high pulse is swallowed
                    if (!raw) begin
                        state  <= ST_LO;
                        pwm_lo <= 1'b1;
                    end else if (dt_cnt <= DT_BITS'(1)) begin
                        state  <= ST_HI;
                        pwm_hi <= 1'b1;
                    end else begin
                        dt_cnt <= dt_cnt - DT_BITS'(1);
                    end
                end
                ST_DT_HL: begin
                    if (raw) begin
                        state  <= ST_HI;
                        pwm_hi <= 1'b1;
                    end else if (dt_cnt <= DT_BITS'(1)) begin
                        state  <= ST_LO;
                        pwm_lo <= 1'b1;
                    end else begin
                        dt_cnt <= dt_cnt - DT_BITS'(1);
                    end
                end
                default: begin
                    state  <= ST_OFF;
                    pwm_hi <= 1'b0;
                    pwm_lo <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/pwm_deadtime_gen.sv
// PWM generator with period-boundary shadowed duty/dead-time and a
// once-per-period strobe; gate drives come from pwm_deadtime_fsm.
module pwm_deadtime_gen
    import mppt_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int DT_BITS  = 4,
    parameter int DUTY_MIN = DUTY_MIN_DEF,
    parameter int DUTY_MAX = DUTY_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [DUTY_W-1:0]  duty,
    input  logic [DT_BITS-1:0] dead_time,
    output logic               pwm_hi,
    output logic               pwm_lo,
    output logic               period_tick,
    output logic [DUTY_W-1:0]  duty_applied
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]      presc;
    logic [DUTY_W-1:0]  cnt;
    logic [DUTY_W-1:0]  duty_sh;
    logic [DT_BITS-1:0] dt_sh;
    logic               en_q;
    logic               adv, wrap, load, raw;

    assign adv  = (presc == PW'(CLK_DIV - 1));
    assign wrap = adv && (cnt == {DUTY_W{1'b1}});
    // Reload at every period start and on the first enabled edge after idle
    assign load = en && (!en_q || wrap);
    assign raw  = (cnt < duty_sh);

    assign duty_applied = duty_sh;

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc       <= '0;
            cnt         <= '0;
            duty_sh     <= DUTY_W'(DUTY_MIN);
            dt_sh       <= '0;
            en_q        <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            en_q        <= en;
            period_tick <= load;
            if (load) begin
                duty_sh <= clamp_duty(duty, DUTY_W'(DUTY_MIN), DUTY_W'(DUTY_MAX));
                dt_sh   <= dead_time;
            end
            if (!en) begin
                presc <= '0;
                cnt   <= '0;
            end else begin
                presc <= adv ? '0 : presc + PW'(1);
                if (adv)
                    cnt <= cnt + DUTY_W'(1);
            end
        end
    end

    pwm_deadtime_fsm #(
        .DT_BITS(DT_BITS)
    ) u_fsm (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .raw    (raw),
        .dt_sh  (dt_sh),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench: three instances (CLK_DIV=1, CLK_DIV=1 with DUTY_MIN=1,
// default CLK_DIV=4) share stimulus; pulse widths are hand-computed.
module tb_pwm_deadtime_gen;
    logic       clk, reset, en;
    logic [7:0] duty;
    logic [3:0] dead_time;

    logic       a_hi, a_lo, a_tick, b_hi, b_lo, b_tick, c_hi, c_lo, c_tick;
    logic [7:0] a_da, b_da, c_da;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_deadtime_gen #(.CLK_DIV(1), .DT_BITS(4), .DUTY_MIN(8), .DUTY_MAX(240)) u_a (
        .clk(clk), .reset(reset), .en(en), .duty(duty), .dead_time(dead_time),
        .pwm_hi(a_hi), .pwm_lo(a_lo), .period_tick(a_tick), .duty_applied(a_da));
    pwm_deadtime_gen #(.CLK_DIV(1), .DT_BITS(4), .DUTY_MIN(1), .DUTY_MAX(240)) u_b (
        .clk(clk), .reset(reset), .en(en), .duty(duty), .dead_time(dead_time),
        .pwm_hi(b_hi), .pwm_lo(b_lo), .period_tick(b_tick), .duty_applied(b_da));
    pwm_deadtime_gen u_c (
        .clk(clk), .reset(reset), .en(en), .duty(duty), .dead_time(dead_time),
        .pwm_hi(c_hi), .pwm_lo(c_lo), .period_tick(c_tick), .duty_applied(c_da));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until instance A shows period_tick; an expired bound counts as a failure.
    task automatic wait_tick(input string name);
        bit seen = 0;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (a_tick) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: period_tick not seen within 3000 clk", name);
        end
    endtask

    // Samples 256 cycles starting at the current (tick) sample; optional mid-period duty change.
    task automatic measure_period(input int chg_at, input logic [7:0] chg_duty,
                                  output int hi_n, output int lo_n, output int both_lo,
                                  output int both_hi, output int ticks,
                                  output logic [7:0] da_last, output int bhi_n, output int blo_n);
        hi_n = 0; lo_n = 0; both_lo = 0; both_hi = 0; ticks = 0; bhi_n = 0; blo_n = 0;
        da_last = 8'h00;
        for (int i = 0; i < 256; i++) begin
            if (i == chg_at) duty = chg_duty;
            hi_n    += int'(a_hi);
            lo_n    += int'(a_lo);
            both_lo += int'(!a_hi && !a_lo);
            both_hi += int'(a_hi && a_lo);
            ticks   += int'(a_tick);
            bhi_n   += int'(b_hi);
            blo_n   += int'(b_lo);
            da_last  = a_da;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; duty = 8'd100; dead_time = 4'd3;
        repeat (3) step();
        n_checks++; if (a_hi !== 1'b0) begin n_fail++; $display("FAIL reset_hi: got %b want 0", a_hi); end
        n_checks++; if (a_lo !== 1'b0) begin n_fail++; $display("FAIL reset_lo: got %b want 0", a_lo); end
        n_checks++; if ({a_tick, b_tick, c_tick} !== 3'b000) begin n_fail++; $display("FAIL reset_tick: got %b want 000", {a_tick, b_tick, c_tick}); end
        n_checks++; if (a_da !== 8'd8) begin n_fail++; $display("FAIL reset_duty_a: got %0d want 8", a_da); end
        n_checks++; if (b_da !== 8'd1) begin n_fail++; $display("FAIL reset_duty_b: got %0d want 1", b_da); end
        n_checks++; if ({b_hi, b_lo, c_hi, c_lo} !== 4'b0000) begin n_fail++; $display("FAIL reset_gates_bc: got %b want 0000", {b_hi, b_lo, c_hi, c_lo}); end
        n_checks++; if (c_da !== 8'd8) begin n_fail++; $display("FAIL reset_duty_c: got %0d want 8", c_da); end
    endtask

    task automatic test_steady();
        int hi, lo, bl, bh, tk, bhi, blo;
        logic [7:0] da;
        duty = 8'd128; dead_time = 4'd3;
        reset = 1'b1;
        wait_tick("steady_first_load");
        wait_tick("steady_wrap");
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (hi != 125) begin n_fail++; $display("FAIL steady_hi: got %0d want 125", hi); end
        n_checks++; if (lo != 125) begin n_fail++; $display("FAIL steady_lo: got %0d want 125", lo); end
        n_checks++; if (bl != 6) begin n_fail++; $display("FAIL steady_gap: got %0d want 6", bl); end
        n_checks++; if (bh != 0) begin n_fail++; $display("FAIL steady_overlap: got %0d want 0", bh); end
        n_checks++; if (tk != 1) begin n_fail++; $display("FAIL steady_ticks: got %0d want 1", tk); end
        n_checks++; if (a_tick !== 1'b1) begin n_fail++; $display("FAIL steady_period: got %b want 1 at 256", a_tick); end
    endtask

    task automatic test_mid_change();
        int hi, lo, bl, bh, tk, bhi, blo;
        logic [7:0] da;
        measure_period(50, 8'd64, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (hi != 125) begin n_fail++; $display("FAIL mid_cur_hi: got %0d want 125", hi); end
        n_checks++; if (da !== 8'd128) begin n_fail++; $display("FAIL mid_cur_applied: got %0d want 128", da); end
        n_checks++; if (a_da !== 8'd64 || a_tick !== 1'b1) begin n_fail++; $display("FAIL mid_load: got %0d/%b want 64/1", a_da, a_tick); end
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (hi != 61) begin n_fail++; $display("FAIL mid_next_hi: got %0d want 61", hi); end
        n_checks++; if (lo != 189) begin n_fail++; $display("FAIL mid_next_lo: got %0d want 189", lo); end
    endtask

    task automatic test_clamp();
        int hi, lo, bl, bh, tk, bhi, blo;
        logic [7:0] da;
        duty = 8'd0;
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (a_da !== 8'd8) begin n_fail++; $display("FAIL clamp_low: got %0d want 8", a_da); end
        duty = 8'd255;
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (hi != 5 || lo != 245) begin n_fail++; $display("FAIL clamp_low_widths: got %0d/%0d want 5/245", hi, lo); end
        n_checks++; if (a_da !== 8'd240) begin n_fail++; $display("FAIL clamp_high: got %0d want 240", a_da); end
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (hi != 237 || lo != 13) begin n_fail++; $display("FAIL clamp_high_widths: got %0d/%0d want 237/13", hi, lo); end
    endtask

    task automatic test_zero_dt();
        int hi, lo, bl, bh, tk, bhi, blo;
        logic [7:0] da;
        duty = 8'd128; dead_time = 4'd0;
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (hi != 127 || lo != 127) begin n_fail++; $display("FAIL zero_dt_widths: got %0d/%0d want 127/127", hi, lo); end
        n_checks++; if (bl != 2 || bh != 0) begin n_fail++; $display("FAIL zero_dt_gap: got %0d/%0d want 2/0", bl, bh); end
    endtask

    task automatic test_swallow();
        int hi, lo, bl, bh, tk, bhi, blo;
        logic [7:0] da;
        duty = 8'd1; dead_time = 4'd5;
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (b_da !== 8'd1) begin n_fail++; $display("FAIL swallow_applied: got %0d want 1", b_da); end
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        n_checks++; if (bhi != 0) begin n_fail++; $display("FAIL swallow_hi: got %0d want 0", bhi); end
        n_checks++; if (blo != 255) begin n_fail++; $display("FAIL swallow_lo: got %0d want 255", blo); end
        n_checks++; if (hi != 3 || lo != 243) begin n_fail++; $display("FAIL swallow_a_widths: got %0d/%0d want 3/243", hi, lo); end
    endtask

    task automatic test_enable();
        int hi, lo, bl, bh, tk, bhi, blo, k;
        logic [7:0] da;
        bit seen;
        duty = 8'd128; dead_time = 4'd4;
        measure_period(-1, 8'd0, hi, lo, bl, bh, tk, da, bhi, blo);
        seen = 0;
        for (int n = 0; n < 300; n++) begin
            if (a_hi) begin seen = 1; break; end
            step();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL en_reach_hi: pwm_hi not seen within 300 clk"); end
        en = 1'b0;
        step();
        n_checks++; if ({a_hi, a_lo, a_tick} !== 3'b000) begin n_fail++; $display("FAIL en_drop: got %b want 000", {a_hi, a_lo, a_tick}); end
        repeat (3) step();
        n_checks++; if ({a_hi, a_lo} !== 2'b00 || a_da !== 8'd128) begin n_fail++; $display("FAIL en_hold: got %b/%0d want 00/128", {a_hi, a_lo}, a_da); end
        en = 1'b1;
        step();
        n_checks++; if (a_tick !== 1'b1 || a_hi !== 1'b0 || a_lo !== 1'b0) begin n_fail++; $display("FAIL en_reload: got tick/hi/lo %b%b%b want 100", a_tick, a_hi, a_lo); end
        repeat (3) step();
        n_checks++; if (a_hi !== 1'b0 || a_lo !== 1'b0) begin n_fail++; $display("FAIL en_dt4: got %b%b want 00 at clk 4", a_hi, a_lo); end
        step();
        n_checks++; if (a_hi !== 1'b1) begin n_fail++; $display("FAIL en_hi_rise: got %b want 1 at clk 5", a_hi); end
        k = 5;
        while (!a_tick && k < 1000) begin step(); k++; end
        n_checks++; if (k != 256) begin n_fail++; $display("FAIL en_cnt_restart: next tick at clk %0d want 256", k); end
    endtask

    task automatic test_clkdiv4();
        int hi, lo, tk, n;
        bit seen;
        reset = 1'b0; en = 1'b1; duty = 8'd100; dead_time = 4'd3;
        repeat (2) step();
        reset = 1'b1;
        for (int t = 0; t < 2; t++) begin
            seen = 0;
            for (n = 0; n < 3000; n++) begin
                step();
                if (c_tick) begin seen = 1; break; end
            end
            n_checks++; if (!seen) begin n_fail++; $display("FAIL div4_tick_wait: no tick within 3000 clk"); end
        end
        hi = 0; lo = 0; tk = 0;
        for (int i = 0; i < 1024; i++) begin
            hi += int'(c_hi); lo += int'(c_lo); tk += int'(c_tick);
            step();
        end
        n_checks++; if (hi != 397 || lo != 621) begin n_fail++; $display("FAIL div4_widths: got %0d/%0d want 397/621", hi, lo); end
        n_checks++; if (tk != 1 || c_tick !== 1'b1) begin n_fail++; $display("FAIL div4_period: got %0d ticks, next %b want 1/1", tk, c_tick); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_mid_change();
        test_clamp();
        test_zero_dt();
        test_swallow();
        test_enable();
        test_clkdiv4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
Downstream power stage of the solar MPPT path. Converts the tracker's 8-bit duty command into complementary high-side/low-side gate drives for the synchronous buck converter, with programmable dead time. The duty command is clamped and latched only at period boundaries, so pulses are always glitch-free. A once-per-period strobe is returned upstream, where the tracker uses it as its step enable.

Parameters:
CLK_DIV, 4, clk cycles per PWM count (≥1); one period = 256*CLK_DIV clk cycles
DT_BITS, 4, width of the dead_time input
DUTY_MIN, 8, lower clamp applied to duty (8-bit)
DUTY_MAX, 240, upper clamp applied to duty (8-bit); must satisfy DUTY_MIN ≤ DUTY_MAX

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
en  in  1  converter enable; low forces both gates off
duty  in  8  duty command from tracker, 0..255 over a 256-count period
dead_time  in  DT_BITS  dead time, in clk cycles
pwm_hi  out  1  high-side gate drive (registered)
pwm_lo  out  1  low-side gate drive (registered)
period_tick  out  1  one-clk pulse at each period start
duty_applied  out  8  clamped duty currently in force

Behaviour:
- Reset (reset==0 at posedge): prescaler=0, cnt=0, duty_sh=DUTY_MIN, dt_sh=0, state=OFF. Outputs: pwm_hi=0, pwm_lo=0, period_tick=0, duty_applied=DUTY_MIN. Reset overrides en.
- Prescaler counts 0..CLK_DIV-1. "adv" is asserted when it equals CLK_DIV-1. On adv, cnt (8-bit) increments and wraps 255→0.
- Shadow load:
  - Occurs on the edge where cnt wraps 255→0, and on the first edge with en=1 after en=0 or reset.
  - duty_sh <= clamp(duty) to [DUTY_MIN, DUTY_MAX].
  - dt_sh <= dead_time.
  - period_tick=1 for exactly that one clk.
  - Changes to duty or dead_time mid-period have no effect until the next load.
- duty_applied = duty_sh.
- raw = (cnt < duty_sh), combinational. High time = duty_sh*CLK_DIV clk cycles per period.
- Gate FSM (registered). States: OFF, HI, DT_HL, LO, DT_LH.
  - Outputs: pwm_hi = (state==HI); pwm_lo = (state==LO). Never both high.
  - OFF: if en, go to DT_LH when raw=1, else DT_HL.
  - LO: if raw=1, go to DT_LH.
  - HI: if raw=0, go to DT_HL.
  - Entering DT_*: dt_cnt <= dt_sh.
  - In DT_*: if dt_cnt ≤ 1, exit to the target (DT_LH→HI, DT_HL→LO); else decrement dt_cnt.
  - DT_* therefore lasts max(dt_sh,1) clk; dead_time=0 behaves as 1.
  - Pulse swallow: DT_LH with raw=0 goes to LO; DT_HL with raw=1 goes to HI. The aborted side never asserts.
- Latency: raw rises at edge E → pwm_lo falls at E+1 → pwm_hi rises at E+1+max(dt,1). The falling edge of raw is symmetric.
- en=0 (synchronous, any state): next edge state=OFF, prescaler and cnt held at 0, period_tick=0. duty_sh and dt_sh are retained until the re-enable load.
- Steady state, with no swallow: pwm_hi high time per period = duty_sh*CLK_DIV − max(dt,1); pwm_lo high time = (256−duty_sh)*CLK_DIV − max(dt,1).

Decomposition:
- Shared package mppt_pkg holds:
  - DUTY_W=8.
  - FSM state encoding localparams (OFF, HI, DT_HL, LO, DT_LH).
  - Default DUTY_MIN/DUTY_MAX constants.
- One natural sub-module: pwm_deadtime_fsm. It takes raw, en and dt_sh, and drives pwm_hi/pwm_lo.
- The counter, prescaler and shadow logic stay in the top level.

Test Plan:
1. Reset behaviour: hold reset=0 with en=1, duty=100 → pwm_hi=0, pwm_lo=0, period_tick=0, duty_applied=8.
2. Steady-state pulse widths: CLK_DIV=1, dead_time=3, duty=128 → period_tick every 256 clk; pwm_hi high 125 clk; pwm_lo high 125 clk; gaps of 3 clk at each transition; pwm_hi & pwm_lo never both 1.
3. Mid-period duty change: CLK_DIV=1, change duty 128→64 at cnt=50 → current period unchanged; next period pwm_hi=61 clk; duty_applied changes on the period_tick edge.
4. Clamping: duty=0 → duty_applied=8; duty=255 → duty_applied=240; pwm_lo never occupies the full period.
5. Zero dead time and pulse swallow: dead_time=0 → 1-clk gap. Separately, with DUTY_MIN=1, duty=1, CLK_DIV=1, dead_time=5 → pwm_hi never asserts and pwm_lo low for 1 clk per period.
6. Enable toggling: drop en while state=HI → both gates 0 on the next edge. Raise en again → period_tick on the first edge and cnt restarts at 0. With dead_time=4, pwm_hi rises at clk 5 after raising en, i.e. 4 clk after the FSM leaves OFF.
